// File: rtl/fifo_sync_cfg_if.sv
// Handshake and status bundle for fifo_sync_cfg: producer/consumer side drives
// the master modport, the FIFO itself binds to the slave modport.
interface fifo_sync_cfg_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  w_inc;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, w_inc, w_data, r_inc,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_inc, w_data, r_inc,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_cfg.sv
// Single-clock FIFO with occupancy flags, error pulses and flush; FWFT=0 gives read data 1 cycle after pop, FWFT=1 shows the head 1 cycle after the first write.
// Backpressure: a write to a full FIFO is refused (overflow pulse) unless a read is accepted the same cycle; a read of an empty FIFO pulses underflow.
module fifo_sync_cfg #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    fifo_sync_cfg_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [ADDR_WIDTH:0]   w_count_next;

    // All flags come straight from the registered count so they never glitch.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_rd_acc = bus.r_inc & ~w_empty;
    assign w_wr_acc = bus.w_inc & (~w_full | w_rd_acc);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   w_count_next = r_count - (ADDR_WIDTH+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count     <= w_count_next;
            r_overflow  <= bus.w_inc & ~w_wr_acc;
            r_underflow <= bus.r_inc & w_empty;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (rst && !bus.flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.w_data;
        end
    end

    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= LP_AF);
    assign bus.almost_empty = (r_count <= LP_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    generate
        if (FWFT) begin : g_fwft
            // Head is masked while empty so the port reads zero out of reset.
            assign bus.r_data  = w_empty ? '0 : r_mem[r_rd_ptr];
            assign bus.r_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (bus.flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign bus.r_data  = r_rd_data;
            assign bus.r_valid = r_rd_valid;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Drives a standard-read and an FWFT instance with identical stimulus and checks
// both against a queue-based model plus a hand-derived vector table.
module tb_fifo_sync_cfg;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    fifo_sync_cfg_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if0 ();
    fifo_sync_cfg_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if1 ();

    fifo_sync_cfg #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    fifo_sync_cfg #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: contents as a queue, plus the registered outputs of the standard port
    logic [15:0] q[$];
    logic [15:0] m_rd0 = 16'h0000;
    logic        m_rv0 = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    typedef struct {
        logic        fl;
        logic        wi;
        logic [15:0] wd;
        logic        ri;
        int          e_cnt;
        logic        e_rv;
        logic [15:0] e_rd;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t tbl[20];
    int   nv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic wi, input logic [15:0] wd, input logic ri);
        if0.flush = fl; if0.w_inc = wi; if0.w_data = wd; if0.r_inc = ri;
        if1.flush = fl; if1.w_inc = wi; if1.w_data = wd; if1.r_inc = ri;
    endtask

    task automatic model_clock(input logic fl, input logic wi, input logic [15:0] wd, input logic ri);
        bit rd, wr;
        if (fl) begin
            q.delete();
            m_rv0 = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            rd    = ri && (q.size() > 0);
            wr    = wi && ((q.size() < DEPTH) || rd);
            m_ovf = wi && !wr;
            m_udf = ri && (q.size() == 0);
            m_rv0 = rd;
            if (rd) m_rd0 = q.pop_front();
            if (wr) q.push_back(wd);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] cnt, input logic fu, input logic em,
                             input logic af, input logic ae, input logic ov, input logic un, input int n);
        chk({tag, ".count"},        32'(cnt), 32'(n));
        chk({tag, ".full"},         32'(fu),  32'(n == DEPTH));
        chk({tag, ".empty"},        32'(em),  32'(n == 0));
        chk({tag, ".almost_full"},  32'(af),  32'(n >= 6));
        chk({tag, ".almost_empty"}, 32'(ae),  32'(n <= 2));
        chk({tag, ".overflow"},     32'(ov),  32'(m_ovf));
        chk({tag, ".underflow"},    32'(un),  32'(m_udf));
    endtask

    task automatic check_all();
        int n = q.size();
        chk_flags("d0", if0.count, if0.full, if0.empty, if0.almost_full, if0.almost_empty,
                  if0.overflow, if0.underflow, n);
        chk_flags("d1", if1.count, if1.full, if1.empty, if1.almost_full, if1.almost_empty,
                  if1.overflow, if1.underflow, n);
        chk("d0.r_valid", 32'(if0.r_valid), 32'(m_rv0));
        chk("d0.r_data",  32'(if0.r_data),  32'(m_rd0));
        chk("d1.r_valid", 32'(if1.r_valid), 32'(n > 0));
        if (n > 0) chk("d1.r_data", 32'(if1.r_data), 32'(q[0]));
    endtask

    task automatic step(input logic fl, input logic wi, input logic [15:0] wd, input logic ri);
        drive(fl, wi, wd, ri);
        @(posedge clk);
        model_clock(fl, wi, wd, ri);
        #1;
        check_all();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".d0.count"},   32'(if0.count),        32'd0);
        chk({tag, ".d0.empty"},   32'(if0.empty),        32'd1);
        chk({tag, ".d0.full"},    32'(if0.full),         32'd0);
        chk({tag, ".d0.ae"},      32'(if0.almost_empty), 32'd1);
        chk({tag, ".d0.af"},      32'(if0.almost_full),  32'd0);
        chk({tag, ".d0.r_data"},  32'(if0.r_data),       32'd0);
        chk({tag, ".d0.r_valid"}, 32'(if0.r_valid),      32'd0);
        chk({tag, ".d0.ovf"},     32'(if0.overflow),     32'd0);
        chk({tag, ".d0.udf"},     32'(if0.underflow),    32'd0);
        chk({tag, ".d1.count"},   32'(if1.count),        32'd0);
        chk({tag, ".d1.empty"},   32'(if1.empty),        32'd1);
        chk({tag, ".d1.r_valid"}, 32'(if1.r_valid),      32'd0);
        chk({tag, ".d1.r_data"},  32'(if1.r_data),       32'd0);
    endtask

    function automatic vec_t mk(input logic fl, input logic wi, input logic [15:0] wd, input logic ri,
                                input int cnt, input logic rv, input logic [15:0] rdat,
                                input logic ov, input logic un);
        vec_t v;
        v.fl = fl; v.wi = wi; v.wd = wd; v.ri = ri;
        v.e_cnt = cnt; v.e_rv = rv; v.e_rd = rdat; v.e_ovf = ov; v.e_udf = un;
        return v;
    endfunction

    initial begin
        logic [15:0] d;
        bit          up;
        int          tog;
        logic        prev_ae;
        int          wp, rp;

        // fill, overflow, full write+read, drain, underflow, idle
        for (int k = 1; k <= 8; k++) begin
            tbl[nv] = mk(1'b0, 1'b1, 16'(k), 1'b0, k, 1'b0, 16'h0000, 1'b0, 1'b0); nv++;
        end
        tbl[nv] = mk(1'b0, 1'b1, 16'hDEAD, 1'b0, 8, 1'b0, 16'h0000, 1'b1, 1'b0); nv++;
        tbl[nv] = mk(1'b0, 1'b1, 16'hBEEF, 1'b1, 8, 1'b1, 16'h0001, 1'b0, 1'b0); nv++;
        for (int j = 1; j <= 8; j++) begin
            tbl[nv] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8 - j, 1'b1,
                         (j < 8) ? 16'(j + 1) : 16'hBEEF, 1'b0, 1'b0); nv++;
        end
        tbl[nv] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'hBEEF, 1'b0, 1'b1); nv++;
        tbl[nv] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 16'hBEEF, 1'b0, 1'b0); nv++;

        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < nv; i++) begin
            step(tbl[i].fl, tbl[i].wi, tbl[i].wd, tbl[i].ri);
            chk($sformatf("tbl[%0d].count", i),     32'(if0.count),     32'(tbl[i].e_cnt));
            chk($sformatf("tbl[%0d].r_valid", i),   32'(if0.r_valid),   32'(tbl[i].e_rv));
            chk($sformatf("tbl[%0d].r_data", i),    32'(if0.r_data),    32'(tbl[i].e_rd));
            chk($sformatf("tbl[%0d].overflow", i),  32'(if0.overflow),  32'(tbl[i].e_ovf));
            chk($sformatf("tbl[%0d].underflow", i), 32'(if0.underflow), 32'(tbl[i].e_udf));
        end

        // flush with pending write and read: both ignored, no error pulse
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 16'(16'h0A00 + k), 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk("flush.count",    32'(if0.count),    32'd0);
        chk("flush.empty",    32'(if0.empty),    32'd1);
        chk("flush.overflow", 32'(if0.overflow), 32'd0);
        chk("flush.r_valid",  32'(if0.r_valid),  32'd0);
        step(1'b0, 1'b1, 16'h0C0D, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("flush.after_rd", 32'(if0.r_data), 32'h0C0D);

        // pointer wrap with occupancy swinging between 2 and 5
        d = 16'h1000;
        step(1'b0, 1'b1, d, 1'b0); d++;
        step(1'b0, 1'b1, d, 1'b0); d++;
        up = 1'b1;
        tog = 0;
        prev_ae = if0.almost_empty;
        for (int i = 0; i < 20; i++) begin
            if (up && q.size() == 5) up = 1'b0;
            else if (!up && q.size() == 2) up = 1'b1;
            if (up) begin
                step(1'b0, 1'b1, d, 1'b0); d++;
            end else begin
                step(1'b0, 1'b0, 16'h0000, 1'b1);
            end
            if (if0.almost_empty != prev_ae) tog++;
            prev_ae = if0.almost_empty;
        end
        chk("wrap.ae_toggled", 32'(tog >= 4), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // fall-through: first word visible without a pop
        step(1'b0, 1'b1, 16'h00AA, 1'b0);
        chk("fwft.r_valid", 32'(if1.r_valid), 32'd1);
        chk("fwft.r_data",  32'(if1.r_data),  32'h00AA);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fwft.pop_valid", 32'(if1.r_valid), 32'd0);
        chk("fwft.std_data",  32'(if0.r_data),  32'h00AA);

        // randomized traffic with shifting write/read bias
        for (int seg = 0; seg < 4; seg++) begin
            wp = (seg == 0) ? 70 : (seg == 1) ? 30 : (seg == 2) ? 50 : 90;
            rp = 100 - wp;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 31) == 0),
                     ($urandom_range(0, 99) < wp),
                     16'($urandom),
                     ($urandom_range(0, 99) < rp));
            end
        end

        // asynchronous reset between clock edges
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'(16'h5A00 + k), 1'b0);
        #3 rst = 1'b0;
        #1 chk_reset("async");
        q.delete();
        m_rd0 = 16'h0000;
        m_rv0 = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #2 rst = 1'b1;
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("async.recover", 32'(if0.r_data), 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
